// File: rtl/piton_aws_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piton_aws_axi_pkg
// Purpose  : Shared types and helpers for the AXI error responder slice.
// Revision : 1.0
// ============================================================================
package piton_aws_axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    localparam int c_ERR_CNT_WIDTH = 32;

    // Up to two handshakes per cycle; clamp at all-ones instead of wrapping.
    function automatic logic [c_ERR_CNT_WIDTH-1:0] sat_add(
        input logic [c_ERR_CNT_WIDTH-1:0] cnt,
        input logic [1:0]                 inc
    );
        logic [c_ERR_CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(c_ERR_CNT_WIDTH-1){1'b0}}, inc};
        return sum[c_ERR_CNT_WIDTH] ? {c_ERR_CNT_WIDTH{1'b1}} : sum[c_ERR_CNT_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/piton_aws_axi_err_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : piton_aws_axi_err_responder_if
// Purpose  : AXI4 bundle (AW/W/B/AR/R) seen by the error responder.
// Revision : 1.0
// ============================================================================
interface piton_aws_axi_err_responder_if #(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/piton_aws_err_rd_gen.sv
`default_nettype none
// ============================================================================
// Module   : piton_aws_err_rd_gen
// Purpose  : Read side of the error responder: arlen+1 fill beats per AR.
// Revision : 1.0
// ============================================================================
module piton_aws_err_rd_gen
    import piton_aws_axi_pkg::*;
#(
    parameter int                    ID_WIDTH   = 16,
    parameter int                    DATA_WIDTH = 512,
    parameter axi_resp_e             RESP_CODE  = DECERR,
    parameter logic [DATA_WIDTH-1:0] FILL_DATA  = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  ar_hs
);
    rd_state_e           r_state;
    rd_state_e           w_state_nxt;
    logic                r_up;
    logic [ID_WIDTH-1:0] r_rid;
    logic [7:0]          r_arlen;
    logic [7:0]          r_beat;
    logic                w_arready;
    logic                w_rvalid;
    logic                w_rlast;
    logic                w_r_hs;

    // r_up keeps arready low through reset and raises it on the first free edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_up    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_up    <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arready   = 1'b0;
        w_rvalid    = 1'b0;
        case (r_state)
            R_IDLE: begin
                w_arready = r_up;
                if (arvalid && r_up) w_state_nxt = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (rready && w_rlast) w_state_nxt = R_IDLE;
            end
            default: w_state_nxt = R_IDLE;
        endcase
    end

    assign w_rlast = (r_beat == r_arlen);
    assign ar_hs   = arvalid & w_arready;
    assign w_r_hs  = w_rvalid & rready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rid   <= '0;
            r_arlen <= '0;
            r_beat  <= '0;
        end else if (ar_hs) begin
            r_rid   <= arid;
            r_arlen <= arlen;
            r_beat  <= '0;
        end else if (w_r_hs && !w_rlast) begin
            r_beat  <= r_beat + 8'd1;
        end
    end

    assign arready = w_arready;
    assign rvalid  = w_rvalid;
    assign rlast   = w_rvalid & w_rlast;
    assign rid     = w_rvalid ? r_rid : '0;
    assign rdata   = w_rvalid ? FILL_DATA : '0;
    assign rresp   = w_rvalid ? RESP_CODE : 2'b00;

endmodule
`default_nettype wire

// File: rtl/piton_aws_axi_err_responder.sv
`default_nettype none
// ============================================================================
// Module   : piton_aws_axi_err_responder
// Purpose  : AXI4 slave that error-terminates non-DDR traffic and logs it.
// Revision : 1.0
// ============================================================================
module piton_aws_axi_err_responder
    import piton_aws_axi_pkg::*;
#(
    parameter int                    ID_WIDTH   = 16,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 512,
    parameter axi_resp_e             RESP_CODE  = DECERR,
    parameter logic [DATA_WIDTH-1:0] FILL_DATA  = '1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    piton_aws_axi_err_responder_if.slave axi,
    input  logic                      err_clr,
    output logic [c_ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                      err_seen,
    output logic [ADDR_WIDTH-1:0]     err_last_addr,
    output logic                      wlen_mismatch
);
    wr_state_e                  r_wr_state;
    wr_state_e                  w_wr_state_nxt;
    logic                       r_up;
    logic [ID_WIDTH-1:0]        r_bid;
    logic [7:0]                 r_awlen;
    logic [7:0]                 r_wbeat;
    logic                       w_awready;
    logic                       w_wready;
    logic                       w_bvalid;
    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_ar_hs;
    logic [c_ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic                       r_err_seen;
    logic [ADDR_WIDTH-1:0]      r_err_last_addr;
    logic                       r_wlen_mismatch;
    logic                       w_unused;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
            r_up       <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_up       <= 1'b1;
        end
    end

    // Burst end is wlast only; awlen is checked, never trusted for termination.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_awready      = 1'b0;
        w_wready       = 1'b0;
        w_bvalid       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                w_awready = r_up;
                if (axi.awvalid && r_up) w_wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (axi.wvalid && axi.wlast) w_wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (axi.bready) w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    assign w_aw_hs = axi.awvalid & w_awready;
    assign w_w_hs  = axi.wvalid & w_wready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bid   <= '0;
            r_awlen <= '0;
            r_wbeat <= '0;
        end else if (w_aw_hs) begin
            r_bid   <= axi.awid;
            r_awlen <= axi.awlen;
            r_wbeat <= '0;
        end else if (w_w_hs) begin
            r_wbeat <= r_wbeat + 8'd1;
        end
    end

    assign axi.awready = w_awready;
    assign axi.wready  = w_wready;
    assign axi.bvalid  = w_bvalid;
    assign axi.bid     = w_bvalid ? r_bid : '0;
    assign axi.bresp   = w_bvalid ? RESP_CODE : 2'b00;

    piton_aws_err_rd_gen #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RESP_CODE  (RESP_CODE),
        .FILL_DATA  (FILL_DATA)
    ) u_rd_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .arid    (axi.arid),
        .arlen   (axi.arlen),
        .arvalid (axi.arvalid),
        .arready (axi.arready),
        .rid     (axi.rid),
        .rdata   (axi.rdata),
        .rresp   (axi.rresp),
        .rlast   (axi.rlast),
        .rvalid  (axi.rvalid),
        .rready  (axi.rready),
        .ar_hs   (w_ar_hs)
    );

    // Clear beats a coincident handshake for the sticky state; the address log still updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt       <= '0;
            r_err_seen      <= 1'b0;
            r_err_last_addr <= '0;
            r_wlen_mismatch <= 1'b0;
        end else begin
            if (err_clr) begin
                r_err_cnt       <= '0;
                r_err_seen      <= 1'b0;
                r_wlen_mismatch <= 1'b0;
            end else begin
                r_err_cnt <= sat_add(r_err_cnt, {1'b0, w_aw_hs} + {1'b0, w_ar_hs});
                if (w_aw_hs || w_ar_hs) r_err_seen <= 1'b1;
                if (w_w_hs && axi.wlast && (r_wbeat != r_awlen)) r_wlen_mismatch <= 1'b1;
            end
            if (w_aw_hs)      r_err_last_addr <= axi.awaddr;
            else if (w_ar_hs) r_err_last_addr <= axi.araddr;
        end
    end

    assign err_cnt       = r_err_cnt;
    assign err_seen      = r_err_seen;
    assign err_last_addr = r_err_last_addr;
    assign wlen_mismatch = r_wlen_mismatch;

    // Write payload is intentionally discarded.
    assign w_unused = ^{axi.wdata, axi.wstrb};

endmodule
`default_nettype wire
